// File: rtl/train_scheduler_if.sv
// Datapath-facing bundle of the training sequencer: completion handshakes
// and result operands in, phase enables and clear strobes out.
interface train_scheduler_if #(
    parameter int NUM_BP  = 4,
    parameter int FINAL_W = 19
);
    logic                f_end_i;
    logic [NUM_BP-1:0]   b_end_i;
    logic                zero_end_check_i;
    logic [FINAL_W-1:0]  final_i;
    logic [FINAL_W-1:0]  target_i;
    logic [FINAL_W-1:0]  tol_i;
    logic                f0_pass_o;
    logic                f1_pass_o;
    logic                b_pass_o;
    logic                zero_loss_o;
    logic                zero_final_o;
    logic                zero_weight_update_o;

    // sequencer side
    modport master (
        input  f_end_i, b_end_i, zero_end_check_i, final_i, target_i, tol_i,
        output f0_pass_o, f1_pass_o, b_pass_o,
               zero_loss_o, zero_final_o, zero_weight_update_o
    );

    // datapath side
    modport slave (
        output f_end_i, b_end_i, zero_end_check_i, final_i, target_i, tol_i,
        input  f0_pass_o, f1_pass_o, b_pass_o,
               zero_loss_o, zero_final_o, zero_weight_update_o
    );
endinterface

// File: rtl/train_scheduler.sv
// Training sequencer: forward pass, convergence check, backward pass over
// NUM_BP units and accumulator clear, repeated per epoch until convergence,
// epoch limit, abort or watchdog expiry.
module train_scheduler #(
    parameter int NUM_BP     = 4,
    parameter int FINAL_W    = 19,
    parameter int EPOCH_W    = 8,
    parameter int MAX_EPOCHS = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               init_i,
    input  logic               abort_i,
    train_scheduler_if.master  dp,
    output logic               busy_o,
    output logic               done_o,
    output logic               converged_o,
    output logic               timeout_o,
    output logic [EPOCH_W-1:0] epoch_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_FWD_INIT, S_FWD, S_CHECK, S_BWD, S_CLEAR, S_DONE, S_ERR
    } state_t;

    localparam logic [EPOCH_W-1:0] EP_LAST = EPOCH_W'(MAX_EPOCHS - 1);
    localparam logic [15:0]        WD_LAST = 16'(TIMEOUT - 1);
    localparam logic [NUM_BP-1:0]  BP_ALL  = '1;

    state_t              state_q, state_d;
    logic [EPOCH_W-1:0]  epoch_q, epoch_d;
    logic [15:0]         wd_q, wd_d;
    logic [NUM_BP-1:0]   mask_q, mask_d;
    logic                init_q, init_d;
    logic                armed_q, armed_d;
    logic                conv_q, conv_d;

    logic                start;
    logic                wd_exp;
    logic                wait_st;
    logic                in_tol;
    logic [FINAL_W-1:0]  diff;

    // Edge detect on init_i. armed_q requires init_i to have been seen low
    // since reset, so an init held high across reset cannot start a run.
    always_comb begin
        init_d  = en_i ? init_i : init_q;
        armed_d = armed_q | (en_i & ~init_i);
        start   = init_i & ~init_q & armed_q;
    end

    // Absolute error and per-state watchdog expiry.
    always_comb begin
        diff    = (dp.final_i >= dp.target_i) ? (dp.final_i - dp.target_i)
                                              : (dp.target_i - dp.final_i);
        in_tol  = (diff <= dp.tol_i);
        wait_st = (state_q == S_FWD_INIT) || (state_q == S_FWD) ||
                  (state_q == S_BWD) || (state_q == S_CLEAR);
        wd_exp  = (wd_q == WD_LAST);
    end

    // State register plus epoch, watchdog, mask and status flops.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            epoch_q <= '0;
            wd_q    <= '0;
            mask_q  <= '0;
            init_q  <= 1'b0;
            armed_q <= 1'b0;
            conv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            epoch_q <= epoch_d;
            wd_q    <= wd_d;
            mask_q  <= mask_d;
            init_q  <= init_d;
            armed_q <= armed_d;
            conv_q  <= conv_d;
        end
    end

    // Next-state: abort beats freeze, completion beats watchdog.
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else if (en_i) begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: if (start) state_d = S_FWD_INIT;
                S_FWD_INIT, S_FWD: begin
                    if (dp.f_end_i)   state_d = S_CHECK;
                    else if (wd_exp)  state_d = S_ERR;
                end
                S_CHECK: begin
                    if (in_tol)                  state_d = S_DONE;
                    else if (epoch_q == EP_LAST) state_d = S_DONE;
                    else                         state_d = S_BWD;
                end
                S_BWD: begin
                    if ((mask_q | dp.b_end_i) == BP_ALL) state_d = S_CLEAR;
                    else if (wd_exp)                     state_d = S_ERR;
                end
                S_CLEAR: begin
                    if (dp.zero_end_check_i) state_d = S_FWD;
                    else if (wd_exp)         state_d = S_ERR;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Epoch, watchdog, backprop mask and converged flag updates.
    always_comb begin
        epoch_d = epoch_q;
        wd_d    = wd_q;
        mask_d  = mask_q;
        conv_d  = conv_q;
        if (abort_i) begin
            epoch_d = '0;
            wd_d    = '0;
            mask_d  = '0;
            conv_d  = 1'b0;
        end else if (en_i) begin
            wd_d = (wait_st && state_d == state_q) ? wd_q + 16'd1 : 16'd0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        epoch_d = '0;
                        mask_d  = '0;
                        conv_d  = 1'b0;
                    end
                end
                S_CHECK: if (state_d == S_DONE) conv_d = in_tol;
                S_BWD:   mask_d = mask_q | dp.b_end_i;
                S_CLEAR: begin
                    if (dp.zero_end_check_i) begin
                        mask_d  = '0;
                        epoch_d = (epoch_q == EP_LAST) ? epoch_q : epoch_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the state register; pass enables drop while frozen.
    always_comb begin
        dp.f0_pass_o            = en_i && (state_q == S_FWD_INIT);
        dp.f1_pass_o            = en_i && (state_q == S_FWD);
        dp.b_pass_o             = en_i && (state_q == S_BWD);
        dp.zero_loss_o          = (state_q == S_CLEAR);
        dp.zero_final_o         = (state_q == S_CLEAR);
        dp.zero_weight_update_o = (state_q == S_CLEAR);
        busy_o      = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
        done_o      = (state_q == S_DONE);
        timeout_o   = (state_q == S_ERR);
        converged_o = conv_q;
        epoch_o     = epoch_q;
    end

endmodule
